ball_ctrl: RTL and testbench

- Per-frame motion controller for the Pong ball.
- Owns ball position, direction, wall and paddle bounces, point scoring and the serve/pause sequence.
- Drives pos_x/pos_y of the ball renderer in the RGB stream pipeline.
- Advances once per frame on frame_tick, which the timing generator issues during vertical blank, so position is stable across active video.

---
 rtl/ball_ctrl.sv | 156 +++++++++++++++
 tb/tb_ball_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ball_ctrl.sv
// ball_ctrl: per-frame Pong ball motion, bounces, scoring and serve/pause sequencing.
// Ports: px_clk/reset_n (sync, active low); frame_tick advances one frame; serve starts play from IDLE;
//        pad_l_y/pad_r_y paddle top rows; pos_x/pos_y ball top-left; score_l/score_r saturating scores;
//        point_l/point_r one-cycle score pulses; state 00 IDLE, 01 MOVE, 10 PAUSE.
module ball_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int SIZE_BALL    = 10,
  parameter int SPEED        = 2,
  parameter int PADDLE_LX    = 16,
  parameter int PADDLE_W     = 6,
  parameter int PADDLE_RX    = 614,
  parameter int PADDLE_H     = 40,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       px_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] pad_l_y,
  input  logic [9:0] pad_r_y,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, MOVE = 2'b01, PAUSE = 2'b10} state_t;
  localparam int CW = $clog2(PAUSE_FRAMES + 1);
  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [10:0] SH   = 11'(SCREEN_H);
  localparam logic [10:0] SB   = 11'(SIZE_BALL);
  localparam logic [10:0] SP   = 11'(SPEED);
  localparam logic [10:0] PRX  = 11'(PADDLE_RX);
  localparam logic [10:0] FACE = 11'(PADDLE_LX + PADDLE_W);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [9:0]  CX   = 10'((SCREEN_W - SIZE_BALL) / 2);
  localparam logic [9:0]  CY   = 10'((SCREEN_H - SIZE_BALL) / 2);
  state_t        state_q, state_d;
  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
  logic          point_l_q, point_l_d, point_r_q, point_r_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          fresh_q, fresh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [10:0]   xe, ye, pl, pr;
  logic          hit_r, hit_l, miss_r, miss_l;
  assign xe = {1'b0, pos_x_q};
  assign ye = {1'b0, pos_y_q};
  assign pl = {1'b0, pad_l_y};
  assign pr = {1'b0, pad_r_y};
  // Paddle hits only when the face is crossed during this frame, so a ball already past the face cannot be caught.
  assign hit_r  = (xe + SB <= PRX) && (xe + SB + SP > PRX) && (ye + SB > pr) && (ye < pr + PH);
  assign hit_l  = (xe >= FACE) && (xe - SP < FACE) && (ye + SB > pl) && (ye < pl + PH);
  assign miss_r = xe + SB + SP > SW;
  assign miss_l = xe < SP;
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    fresh_d   = fresh_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: state_d = serve ? MOVE : IDLE;
      MOVE: if (frame_tick) begin
        if (dir_y_q) begin
          pos_y_d = (ye + SP + SB >= SH) ? 10'(SH - SB) : 10'(ye + SP);
          dir_y_d = !(ye + SP + SB >= SH);
        end else begin
          pos_y_d = (ye < SP) ? 10'd0 : 10'(ye - SP);
          dir_y_d = ye < SP;
        end
        if (dir_x_q) begin
          if (hit_r) begin
            pos_x_d = 10'(PRX - SB);
            dir_x_d = 1'b0;
          end else if (miss_r) begin
            pos_x_d   = 10'(SW - SB);
            score_l_d = (score_l_q == 4'd15) ? 4'd15 : score_l_q + 4'd1;
            point_l_d = 1'b1;
            dir_x_d   = 1'b1;
            fresh_d   = 1'b1;
            state_d   = PAUSE;
          end else
            pos_x_d = 10'(xe + SP);
        end else begin
          if (hit_l) begin
            pos_x_d = 10'(FACE);
            dir_x_d = 1'b1;
          end else if (miss_l) begin
            pos_x_d   = 10'd0;
            score_r_d = (score_r_q == 4'd15) ? 4'd15 : score_r_q + 4'd1;
            point_r_d = 1'b1;
            dir_x_d   = 1'b0;
            fresh_d   = 1'b1;
            state_d   = PAUSE;
          end else
            pos_x_d = 10'(xe - SP);
        end
      end
      PAUSE: if (fresh_q) begin
        // Edge position is shown for the entry cycle only, then the ball recentres.
        pos_x_d = CX;
        pos_y_d = CY;
        cnt_d   = '0;
        fresh_d = 1'b0;
      end else if (frame_tick) begin
        cnt_d   = (cnt_q + CW'(1) == CW'(PAUSE_FRAMES)) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q + CW'(1) == CW'(PAUSE_FRAMES)) ? IDLE : PAUSE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pos_x_q   <= CX;
      pos_y_q   <= CY;
      score_l_q <= '0;
      score_r_q <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      fresh_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      fresh_q   <= fresh_d;
      cnt_q     <= cnt_d;
    end
  end
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign point_l = point_l_q;
  assign point_r = point_r_q;
  assign state   = state_q;
endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed scenario checks for ball_ctrl.
module tb_ball_ctrl;
  logic       px_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] pad_l_y = 10'd1000;
  logic [9:0] pad_r_y = 10'd1000;
  logic [9:0] pos_x, pos_y;
  logic [3:0] score_l, score_r;
  logic       point_l, point_r;
  logic [1:0] state;
  int n_vec = 0;
  int n_err = 0;
  ball_ctrl dut (
    .px_clk(px_clk), .reset_n(reset_n), .frame_tick(frame_tick), .serve(serve),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .pos_x(pos_x), .pos_y(pos_y),
    .score_l(score_l), .score_r(score_r), .point_l(point_l), .point_r(point_r), .state(state)
  );
  always #5 px_clk = ~px_clk;
  task automatic cyc;
    @(posedge px_clk);
    #1;
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask
  task automatic do_reset;
    serve = 1'b0;
    frame_tick = 1'b0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask
  task automatic do_serve;
    serve = 1'b1;
    cyc();
    serve = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    n_vec++; if ({pos_x, pos_y} !== {10'd315, 10'd235}) begin n_err++; $display("FAIL reset_pos got (%0d,%0d) want (315,235)", pos_x, pos_y); end
    n_vec++; if ({score_l, score_r, point_l, point_r} !== 10'd0) begin n_err++; $display("FAIL reset_score got l=%0d r=%0d pl=%b pr=%b want zeros", score_l, score_r, point_l, point_r); end
    n_vec++; if (state !== 2'b00) begin n_err++; $display("FAIL reset_state got %b want 00", state); end
  endtask
  task automatic test_serve_move;
    do_reset();
    serve = 1'b1;
    frame_tick = 1'b1;
    cyc();
    serve = 1'b0;
    frame_tick = 1'b0;
    cyc();
    n_vec++; if ({state, pos_x, pos_y} !== {2'b01, 10'd315, 10'd235}) begin n_err++; $display("FAIL serve_tick_ignored got st=%b (%0d,%0d) want 01 (315,235)", state, pos_x, pos_y); end
    tick_n(10);
    n_vec++; if ({state, pos_x, pos_y} !== {2'b01, 10'd335, 10'd255}) begin n_err++; $display("FAIL move10 got st=%b (%0d,%0d) want 01 (335,255)", state, pos_x, pos_y); end
    repeat (3) cyc();
    n_vec++; if ({pos_x, pos_y} !== {10'd335, 10'd255}) begin n_err++; $display("FAIL hold_no_tick got (%0d,%0d) want (335,255)", pos_x, pos_y); end
  endtask
  task automatic test_bottom_wall;
    do_reset();
    pad_r_y = 10'd1000;
    do_serve();
    tick_n(116);
    n_vec++; if (pos_y !== 10'd467) begin n_err++; $display("FAIL bottom_t116 got %0d want 467", pos_y); end
    tick_n(1);
    n_vec++; if (pos_y !== 10'd469) begin n_err++; $display("FAIL bottom_t117 got %0d want 469", pos_y); end
    tick_n(1);
    n_vec++; if (pos_y !== 10'd470) begin n_err++; $display("FAIL bottom_clamp got %0d want 470", pos_y); end
    tick_n(1);
    n_vec++; if (pos_y !== 10'd468) begin n_err++; $display("FAIL bottom_up got %0d want 468", pos_y); end
  endtask
  task automatic test_paddles;
    do_reset();
    pad_r_y = 10'd400;
    pad_l_y = 10'd150;
    do_serve();
    tick_n(144);
    n_vec++; if (pos_x !== 10'd603) begin n_err++; $display("FAIL rpad_t144 got %0d want 603", pos_x); end
    tick_n(1);
    n_vec++; if ({pos_x, pos_y} !== {10'd604, 10'd416}) begin n_err++; $display("FAIL rpad_hit got (%0d,%0d) want (604,416)", pos_x, pos_y); end
    tick_n(1);
    n_vec++; if (pos_x !== 10'd602) begin n_err++; $display("FAIL rpad_left got %0d want 602", pos_x); end
    tick_n(290);
    n_vec++; if ({pos_x, pos_y} !== {10'd22, 10'd164}) begin n_err++; $display("FAIL lpad_t436 got (%0d,%0d) want (22,164)", pos_x, pos_y); end
    tick_n(1);
    n_vec++; if ({pos_x, pos_y} !== {10'd22, 10'd166}) begin n_err++; $display("FAIL lpad_hit got (%0d,%0d) want (22,166)", pos_x, pos_y); end
    tick_n(1);
    n_vec++; if (pos_x !== 10'd24) begin n_err++; $display("FAIL lpad_right got %0d want 24", pos_x); end
  endtask
  task automatic test_right_miss;
    do_reset();
    pad_r_y = 10'd0;
    pad_l_y = 10'd0;
    do_serve();
    tick_n(157);
    n_vec++; if (pos_x !== 10'd629) begin n_err++; $display("FAIL miss_t157 got %0d want 629", pos_x); end
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    n_vec++; if ({pos_x, score_l, point_l, point_r, state} !== {10'd630, 4'd1, 1'b1, 1'b0, 2'b10}) begin n_err++; $display("FAIL miss_score got x=%0d sl=%0d pl=%b pr=%b st=%b want x=630 sl=1 pl=1 pr=0 st=10", pos_x, score_l, point_l, point_r, state); end
    cyc();
    n_vec++; if ({pos_x, pos_y, point_l} !== {10'd315, 10'd235, 1'b0}) begin n_err++; $display("FAIL pause_centre got (%0d,%0d) pl=%b want (315,235) pl=0", pos_x, pos_y, point_l); end
    do_serve();
    tick_n(59);
    n_vec++; if ({state, pos_x} !== {2'b10, 10'd315}) begin n_err++; $display("FAIL pause_t59 got st=%b x=%0d want 10 x=315", state, pos_x); end
    tick_n(1);
    n_vec++; if (state !== 2'b00) begin n_err++; $display("FAIL pause_done got %b want 00", state); end
    do_serve();
    tick_n(1);
    n_vec++; if ({pos_x, pos_y, score_l, score_r} !== {10'd317, 10'd233, 4'd1, 4'd0}) begin n_err++; $display("FAIL reserve got (%0d,%0d) sl=%0d sr=%0d want (317,233) 1 0", pos_x, pos_y, score_l, score_r); end
  endtask
  task automatic test_saturation;
    int pulses;
    do_reset();
    pad_r_y = 10'd1000;
    pad_l_y = 10'd1000;
    pulses = 0;
    for (int p = 0; p < 16; p++) begin
      do_serve();
      for (int t = 0; t < 200; t++) begin
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        if (point_l) begin
          pulses++;
          break;
        end
        cyc();
      end
      cyc();
      tick_n(60);
    end
    n_vec++; if (pulses !== 16) begin n_err++; $display("FAIL sat_pulses got %0d want 16", pulses); end
    n_vec++; if ({score_l, score_r, state} !== {4'd15, 4'd0, 2'b00}) begin n_err++; $display("FAIL sat_score got sl=%0d sr=%0d st=%b want 15 0 00", score_l, score_r, state); end
  endtask
  task automatic test_reset_mid;
    do_serve();
    tick_n(50);
    n_vec++; if (pos_x !== 10'd415) begin n_err++; $display("FAIL mid_t50 got %0d want 415", pos_x); end
    reset_n = 1'b0;
    frame_tick = 1'b1;
    cyc();
    reset_n = 1'b1;
    frame_tick = 1'b0;
    n_vec++; if ({pos_x, pos_y, score_l, score_r, point_l, point_r, state} !== {10'd315, 10'd235, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00}) begin n_err++; $display("FAIL mid_reset got (%0d,%0d) sl=%0d sr=%0d st=%b want (315,235) 0 0 00", pos_x, pos_y, score_l, score_r, state); end
    tick_n(3);
    n_vec++; if ({pos_x, pos_y, state} !== {10'd315, 10'd235, 2'b00}) begin n_err++; $display("FAIL mid_needs_serve got (%0d,%0d) st=%b want (315,235) 00", pos_x, pos_y, state); end
  endtask
  initial begin
    cyc();
    test_reset();
    test_serve_move();
    test_bottom_wall();
    test_paddles();
    test_right_miss();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
